// File: rtl/alarm_sequencer.sv
// Alarm clock sequencer: setpoint registers, arm/ring/snooze state machine,
// ring timeout and snooze countdown driven by the 1 Hz tick.
module alarm_sequencer #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       sysCLK,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       alarm_en,
  input  logic       set_hour_p,
  input  logic       set_min_p,
  input  logic       snooze_p,
  input  logic       stop_p,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       play_sound,
  output logic       snoozing,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt
);

  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic          play_q, play_d;
  logic          snz_out_q, snz_out_d;
  logic [1:0]    scnt_q, scnt_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [SW-1:0] snz_q, snz_d;

  logic          set_ok;
  logic          match;
  logic          snz_allowed;
  logic [RW-1:0] ring_inc;

  always_comb begin
    set_ok      = (state_q == IDLE) || (state_q == ARMED);
    match       = tick_1hz
               && (cur_hour == hour_q)
               && (cur_min == min_q)
               && (cur_sec == 6'd0);
    snz_allowed = int'(scnt_q) < MAX_SNOOZE;
    ring_inc    = ring_q + RW'(1);
  end

  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    if (set_ok && set_hour_p) begin
      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end
    if (set_ok && set_min_p) begin
      min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    unique case (state_q)
      IDLE: begin
        if (alarm_en) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!alarm_en) begin
          state_d = IDLE;
        end else if (match) begin
          state_d = RINGING;
          ring_d  = '0;
        end
      end
      RINGING: begin
        if (!alarm_en || stop_p) begin
          state_d = alarm_en ? ARMED : IDLE;
          scnt_d  = '0;
          ring_d  = '0;
          snz_d   = '0;
        end else if (snooze_p && snz_allowed) begin
          state_d = SNOOZE;
          scnt_d  = (scnt_q == 2'd3) ? 2'd3 : scnt_q + 2'd1;
          snz_d   = SW'(SNOOZE_S);
        end else if (tick_1hz) begin
          if (ring_inc == RW'(RING_TIMEOUT_S)) begin
            state_d = ARMED;
            scnt_d  = '0;
            ring_d  = '0;
            snz_d   = '0;
          end else begin
            ring_d = ring_inc;
          end
        end
      end
      SNOOZE: begin
        if (!alarm_en || stop_p) begin
          state_d = alarm_en ? ARMED : IDLE;
          scnt_d  = '0;
          ring_d  = '0;
          snz_d   = '0;
        end else if (tick_1hz) begin
          // a load of 0 or 1 both end on this tick; never wrap below zero
          if (snz_q <= SW'(1)) begin
            state_d = RINGING;
            ring_d  = '0;
            snz_d   = '0;
          end else begin
            snz_d = snz_q - SW'(1);
          end
        end
      end
    endcase
    play_d    = (state_d == RINGING);
    snz_out_d = (state_d == SNOOZE);
  end

  always_ff @(posedge sysCLK or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hour_q    <= '0;
      min_q     <= '0;
      play_q    <= 1'b0;
      snz_out_q <= 1'b0;
      scnt_q    <= '0;
      ring_q    <= '0;
      snz_q     <= '0;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      play_q    <= play_d;
      snz_out_q <= snz_out_d;
      scnt_q    <= scnt_d;
      ring_q    <= ring_d;
      snz_q     <= snz_d;
    end
  end

  assign alarm_hour = hour_q;
  assign alarm_min  = min_q;
  assign play_sound = play_q;
  assign snoozing   = snz_out_q;
  assign state      = state_q;
  assign snooze_cnt = scnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_alarm_sequencer;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] A = 2'd1;
  localparam logic [1:0] R = 2'd2;
  localparam logic [1:0] S = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hour = 5'd12;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd5;
  logic       alarm_en = 1'b0;
  logic       set_hour_p = 1'b0;
  logic       set_min_p = 1'b0;
  logic       snooze_p = 1'b0;
  logic       stop_p = 1'b0;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       play_sound;
  logic       snoozing;
  logic [1:0] state;
  logic [1:0] snooze_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       ps;
    logic       sn;
    logic [1:0] sc;
    logic [4:0] ah;
    logic [5:0] am;
  } exp_t;

  exp_t q[$];
  exp_t m;

  alarm_sequencer #(
    .RING_TIMEOUT_S(4),
    .SNOOZE_S(2),
    .MAX_SNOOZE(3)
  ) dut (
    .sysCLK(clk),
    .rst(rst),
    .tick_1hz(tick_1hz),
    .cur_hour(cur_hour),
    .cur_min(cur_min),
    .cur_sec(cur_sec),
    .alarm_en(alarm_en),
    .set_hour_p(set_hour_p),
    .set_min_p(set_min_p),
    .snooze_p(snooze_p),
    .stop_p(stop_p),
    .alarm_hour(alarm_hour),
    .alarm_min(alarm_min),
    .play_sound(play_sound),
    .snoozing(snoozing),
    .state(state),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      m = q.pop_front();
      total++;
      if (state !== m.st || play_sound !== m.ps || snoozing !== m.sn
          || snooze_cnt !== m.sc || alarm_hour !== m.ah
          || alarm_min !== m.am) begin
        bad++;
        $display("FAIL %s: got st=%0d ps=%0d sn=%0d sc=%0d %0d:%0d want st=%0d ps=%0d sn=%0d sc=%0d %0d:%0d",
                 m.name, state, play_sound, snoozing, snooze_cnt,
                 alarm_hour, alarm_min, m.st, m.ps, m.sn, m.sc, m.ah, m.am);
      end
    end
  end

  task automatic expect_o(input string n, input logic [1:0] st,
                          input logic ps, input logic sn,
                          input logic [1:0] sc, input logic [4:0] ah,
                          input logic [5:0] am);
    exp_t e;
    e.name = n;
    e.st = st;
    e.ps = ps;
    e.sn = sn;
    e.sc = sc;
    e.ah = ah;
    e.am = am;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    set_hour_p = 1'b0;
    set_min_p = 1'b0;
    snooze_p = 1'b0;
    stop_p = 1'b0;
  endtask

  task automatic fire();
    cur_hour = 5'd6;
    cur_min = 6'd30;
    cur_sec = 6'd0;
    tick_1hz = 1'b1;
    step();
    cur_sec = 6'd5;
  endtask

  initial begin
    #1;
    expect_o("reset", I, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 59; i++) begin
      set_min_p = 1'b1;
      step();
    end
    expect_o("min59", I, 0, 0, 0, 0, 59);
    set_min_p = 1'b1;
    step();
    expect_o("min_wrap", I, 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) begin
      set_hour_p = 1'b1;
      step();
    end
    expect_o("hour23", I, 0, 0, 0, 23, 0);
    set_hour_p = 1'b1;
    step();
    expect_o("hour_wrap", I, 0, 0, 0, 0, 0);
    set_hour_p = 1'b1;
    set_min_p = 1'b1;
    step();
    expect_o("both_set", I, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      set_hour_p = 1'b1;
      step();
    end
    for (int i = 0; i < 29; i++) begin
      set_min_p = 1'b1;
      step();
    end
    expect_o("set_0630", I, 0, 0, 0, 6, 30);

    alarm_en = 1'b1;
    step();
    expect_o("armed", A, 0, 0, 0, 6, 30);
    cur_hour = 5'd6;
    cur_min = 6'd30;
    cur_sec = 6'd0;
    step();
    expect_o("no_tick", A, 0, 0, 0, 6, 30);
    cur_sec = 6'd1;
    tick_1hz = 1'b1;
    step();
    expect_o("sec_ne0", A, 0, 0, 0, 6, 30);
    fire();
    expect_o("fire", R, 1, 0, 0, 6, 30);
    set_hour_p = 1'b1;
    set_min_p = 1'b1;
    step();
    expect_o("set_in_ring", R, 1, 0, 0, 6, 30);

    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1;
      step();
    end
    expect_o("ring3", R, 1, 0, 0, 6, 30);
    tick_1hz = 1'b1;
    step();
    expect_o("timeout", A, 0, 0, 0, 6, 30);
    fire();
    expect_o("refire", R, 1, 0, 0, 6, 30);

    for (int k = 1; k <= 3; k++) begin
      snooze_p = 1'b1;
      step();
      expect_o($sformatf("snooze%0d", k), S, 0, 1, 2'(k), 6, 30);
      snooze_p = 1'b1;
      step();
      expect_o($sformatf("snz_ign%0d", k), S, 0, 1, 2'(k), 6, 30);
      tick_1hz = 1'b1;
      step();
      expect_o($sformatf("snz_tick%0d", k), S, 0, 1, 2'(k), 6, 30);
      tick_1hz = 1'b1;
      step();
      expect_o($sformatf("rering%0d", k), R, 1, 0, 2'(k), 6, 30);
    end
    snooze_p = 1'b1;
    step();
    expect_o("snooze4_ign", R, 1, 0, 3, 6, 30);

    stop_p = 1'b1;
    snooze_p = 1'b1;
    step();
    expect_o("stop_snz", A, 0, 0, 0, 6, 30);
    fire();
    expect_o("fire2", R, 1, 0, 0, 6, 30);
    alarm_en = 1'b0;
    stop_p = 1'b1;
    step();
    expect_o("en_stop", I, 0, 0, 0, 6, 30);

    alarm_en = 1'b1;
    step();
    expect_o("rearm", A, 0, 0, 0, 6, 30);
    fire();
    snooze_p = 1'b1;
    step();
    expect_o("snz_again", S, 0, 1, 1, 6, 30);
    tick_1hz = 1'b1;
    stop_p = 1'b1;
    step();
    expect_o("tick_stop", A, 0, 0, 0, 6, 30);

    fire();
    snooze_p = 1'b1;
    step();
    expect_o("snz_pre_rst", S, 0, 1, 1, 6, 30);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 expect_o("async_rst", I, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    expect_o("post_rst", A, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
